// File: rtl/random_arbiter.sv
// Shares one 16-bit Galois LFSR between NUM_REQ requesters through a round-robin arbiter.
// Each grant hands out the current generator value and steps the generator exactly once.
module random_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          WARMUP  = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               seed_load_i,
    input  logic [15:0]        seed_in_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [15:0]        rand_out_o,
    output logic               rand_valid_o,
    output logic               busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_WARM  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    localparam state_t     START_ST  = (WARMUP == 0) ? ST_SERVE : ST_WARM;
    localparam logic [7:0] CNT_INIT  = 8'(WARMUP);
    localparam logic       BUSY_INIT = (WARMUP != 0);

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    state_t             state_q;
    logic [7:0]         cnt_q;
    logic [15:0]        lfsr_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [15:0]        rand_q;
    logic               vld_q;
    logic               busy_q;

    logic [15:0]        lfsr_d;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    int                 cand;

    assign lfsr_d = lfsr_step(lfsr_q);

    // Search starts just after the last winner and wraps; first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
        win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= START_ST;
            cnt_q   <= CNT_INIT;
            lfsr_q  <= SEED;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            rand_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= BUSY_INIT;
        end else if (seed_load_i) begin
            state_q <= START_ST;
            cnt_q   <= CNT_INIT;
            lfsr_q  <= (seed_in_i == 16'h0000) ? SEED : seed_in_i;
            gnt_q   <= '0;
            rand_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= BUSY_INIT;
        end else begin
            gnt_q  <= '0;
            rand_q <= '0;
            vld_q  <= 1'b0;
            if (state_q == ST_WARM) begin
                // The edge that takes the last warm-up step also enters SERVE, with no grant.
                lfsr_q <= lfsr_d;
                cnt_q  <= cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_q <= ST_SERVE;
                    busy_q  <= 1'b0;
                end
            end else if (win_found) begin
                gnt_q  <= win_onehot;
                rand_q <= lfsr_q;
                vld_q  <= 1'b1;
                lfsr_q <= lfsr_d;
                ptr_q  <= win_idx;
            end
        end
    end

    assign gnt_o        = gnt_q;
    assign rand_out_o   = rand_q;
    assign rand_valid_o = vld_q;
    assign busy_o       = busy_q;

endmodule

// File: doc/random_arbiter.md
# random_arbiter

Shares one 16-bit pseudo-random source between up to NUM_REQ requesters (mutation, crossover and selection units of the neuroevolution engine). It contains its own steppable Galois LFSR and a round-robin arbiter. Every grant hands one 16-bit value to one requester and advances the generator exactly once, so each value is consumed by exactly one requester. It also owns seeding and a post-seed warm-up sequence.

## Interface
- NUM_REQ, default 4: number of requesters, legal range 2..8.
- SEED, default 16'hACE1: reset seed; also substituted for a zero seed_in.
- WARMUP, default 16: generator steps run after reset or reseed before any grant; legal range 0..255.
- clock, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- seed_load, in, 1: load seed_in into the generator this edge.
- seed_in, in, 16: new seed; 16'h0000 is replaced by SEED.
- req, in, NUM_REQ: level request per requester. While held high, it requests one value per grant.
- gnt, out, NUM_REQ: registered; one-hot or zero; a 1-cycle pulse per delivered value.
- rand_out, out, 16: registered; the value for the requester granted this cycle; 0 when rand_valid=0.
- rand_valid, out, 1: registered; equals |gnt.
- busy, out, 1: registered; 1 while in WARMUP.

## Operation
- Generator step: if x[0]=1, next = (x>>1) ^ 16'hB400; otherwise next = x>>1. This is a maximal-length Galois LFSR with period 65535. State 0 is unreachable.
- FSM states:
  - WARMUP: a counter loads WARMUP. Each cycle the generator steps once and the counter decrements. When the counter reaches 0, go to SERVE. If WARMUP=0, enter SERVE directly without stepping.
  - SERVE: if req≠0, pick the winner, register gnt, and present the current state x on rand_out. Step the generator in the same edge. If req=0, the generator holds; it never steps without a grant.
- Round-robin selection:
  - A pointer holds the index of the last winner; reset value is NUM_REQ-1, so req[0] has first priority.
  - Search order is pointer+1, pointer+2, … modulo NUM_REQ. The first set bit wins, and the pointer updates to the winner.
  - A single requester holding req high is granted every cycle.
- Priority of events at an edge: reset > seed_load > grant.
- seed_load:
  - Generator loads seed_in, or SEED if seed_in=0.
  - The pointer is unchanged, the warm-up counter reloads, and the FSM goes to WARMUP, or SERVE if WARMUP=0.
  - No grant is issued at that edge, regardless of state or req.
- Reset:
  - Generator = SEED, pointer = NUM_REQ-1, FSM = WARMUP (or SERVE if WARMUP=0), counter = WARMUP.
  - gnt=0, rand_out=0, rand_valid=0, busy=(WARMUP≠0).
  - Reset mid-warm-up or mid-stream discards all progress.
- Any req bits at index ≥ NUM_REQ do not exist. Requesters count grants themselves; the block does no per-requester quotas.

## Timing
- Latency: req sampled at edge e produces gnt/rand_out/rand_valid valid during the cycle after e. Throughput is 1 value per cycle.
- A requester that drops req after seeing its gnt may receive one more grant, issued at the edge where gnt is first visible. Requesters must tolerate or discard it.
- busy falls in the same cycle in which the FSM is in SERVE; the first grant can follow busy=0 by one edge.
- The WARMUP-to-SERVE transition edge issues no grant. With WARMUP=N, the first grant is issued at edge N+1 after reset deassertion.
- seed_load clears gnt/rand_valid in the following cycle.
- rand_out shows state x before the step, so the first value after seeding with WARMUP=0 is the seed itself.

## Test plan
- WARMUP=0, reset, then req=4'b0001 held. Required: rand_out sequence 16'hACE1, 16'hE270, 16'h7138 on consecutive cycles; gnt=0001 and rand_valid=1 each cycle.
- WARMUP=0, req=4'b1111 held 6 cycles. Required: gnt 0001, 0010, 0100, 1000, 0001, 0010. Values must match the single-requester sequence in order, with none duplicated.
- WARMUP=0, req=1111 for 2 grants, then req=0 for 3 cycles, then req=0100. Required: rand_valid=0 while idle. The next value is 16'h7138, because the generator did not step while idle.
- seed_load=1 with seed_in=0 and req=1111 in the same cycle. Required: no gnt the next cycle; the first subsequent value is 16'hACE1 (WARMUP=0). Repeat with seed_in=16'h0001; the first value is 16'h0001, then 16'hB400.
- WARMUP=16: reset with req=0001 held. Required: busy=1 for 16 cycles, no gnt until busy=0; the first value equals SEED stepped 16 times. Assert reset at warm-up cycle 7; the count restarts and the same first value results.
